// File: rtl/byter_pkg.sv
// Shared constants, fetch FSM state type and opcode helpers for the byter core.
package byter_pkg;

  localparam int ADDR_W  = 12;
  localparam int LIT_BIT = 7;

  typedef enum logic [1:0] {
    FETCH_OP  = 2'd0,
    FETCH_LIT = 2'd1,
    HOLD      = 2'd2
  } fetch_state_e;

  // True when the opcode is followed by a literal byte.
  function automatic logic has_literal(input logic [7:0] op);
    return op[LIT_BIT];
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, byte fetch over req/ack, and opcode/literal
// hand-off to the decoder over valid/ready. jump_en overrides everything but reset.
module fetch_unit
  import byter_pkg::*;
#(
  parameter int                ADDR_W   = byter_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                LIT_BIT  = byter_pkg::LIT_BIT
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  output logic              instr_valid,
  output logic [7:0]        instr_op,
  output logic [7:0]        instr_lit,
  input  logic              instr_ready,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [ADDR_W-1:0] pc
);

  fetch_state_e state, state_next;
  logic [ADDR_W-1:0] pc_inc;

  assign pc_inc = pc + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH_OP;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (jump_en) begin
      state_next = FETCH_OP;
    end else begin
      case (state)
        FETCH_OP:  if (mem_ack) state_next = mem_data[LIT_BIT] ? FETCH_LIT : HOLD;
        FETCH_LIT: if (mem_ack) state_next = HOLD;
        HOLD:      if (instr_ready) state_next = FETCH_OP;
        default:   state_next = FETCH_OP;
      endcase
    end
  end

  always_comb begin
    mem_req     = 1'b0;
    instr_valid = 1'b0;
    if (!reset) begin
      mem_req     = (state == FETCH_OP) || (state == FETCH_LIT);
      instr_valid = (state == HOLD);
    end
  end

  assign mem_addr = pc;

  // A jump discards any same-cycle ack, so captured bytes and pc+1 only
  // happen on the non-jump path.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_PC;
      instr_op  <= '0;
      instr_lit <= '0;
    end else if (jump_en) begin
      pc <= jump_target;
    end else begin
      case (state)
        FETCH_OP: begin
          if (mem_ack) begin
            instr_op <= mem_data;
            pc       <= pc_inc;
            if (!mem_data[LIT_BIT]) instr_lit <= '0;
          end
        end
        FETCH_LIT: begin
          if (mem_ack) begin
            instr_lit <= mem_data;
            pc        <= pc_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: byte-array program memory that acks every
// request when enabled, with hand-computed expectations step by step.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [7:0]  mem_data;
  logic        instr_valid;
  logic [7:0]  instr_op;
  logic [7:0]  instr_lit;
  logic        instr_ready;
  logic        jump_en;
  logic [11:0] jump_target;
  logic [11:0] pc;

  logic        ack_en;
  logic [7:0]  mem [0:4095];
  int          total  = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  assign mem_data = mem[mem_addr];
  assign mem_ack  = ack_en & mem_req;

  fetch_unit #(.ADDR_W(12), .RESET_PC(12'h000), .LIT_BIT(7)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_addr    (mem_addr),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data),
    .instr_valid (instr_valid),
    .instr_op    (instr_op),
    .instr_lit   (instr_lit),
    .instr_ready (instr_ready),
    .jump_en     (jump_en),
    .jump_target (jump_target),
    .pc          (pc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_hold(input string tag, input logic [7:0] op, input logic [7:0] lit,
                            input logic [11:0] exp_pc);
    check({tag, "_valid"}, 32'(instr_valid), 32'd1);
    check({tag, "_op"},    32'(instr_op),    32'(op));
    check({tag, "_lit"},   32'(instr_lit),   32'(lit));
    check({tag, "_pc"},    32'(pc),          32'(exp_pc));
    check({tag, "_req"},   32'(mem_req),     32'd0);
  endtask

  initial begin
    for (int unsigned i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h000] = 8'h12;
    mem[12'h001] = 8'h85;
    mem[12'h002] = 8'h3C;
    mem[12'h003] = 8'h07;
    mem[12'hFFF] = 8'h80;
    mem[12'h2A0] = 8'h21;
    mem[12'h2A1] = 8'h9A;
    mem[12'h2A2] = 8'h44;

    reset = 1'b1; jump_en = 1'b0; jump_target = '0; instr_ready = 1'b1; ack_en = 1'b1;
    step(); step();
    check("rst_pc",    32'(pc),          32'h000);
    check("rst_req",   32'(mem_req),     32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_op",    32'(instr_op),    32'h00);
    check("rst_lit",   32'(instr_lit),   32'h00);
    reset = 1'b0;
    #1;
    check("fetch0_req",  32'(mem_req),  32'd1);
    check("fetch0_addr", 32'(mem_addr), 32'h000);

    // 1-byte instruction reaches HOLD one cycle after FETCH_OP
    step();
    check_hold("i0", 8'h12, 8'h00, 12'h001);
    step();
    check("i1_fetch_valid", 32'(instr_valid), 32'd0);
    check("i1_fetch_addr",  32'(mem_addr),    32'h001);
    step();
    check("i1_lit_valid", 32'(instr_valid), 32'd0);
    check("i1_lit_addr",  32'(mem_addr),    32'h002);
    check("i1_lit_req",   32'(mem_req),     32'd1);
    step();
    check_hold("i1", 8'h85, 8'h3C, 12'h003);

    // decoder stalls for 5 cycles
    instr_ready = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      step();
      check_hold("stall", 8'h85, 8'h3C, 12'h003);
    end

    // memory withholds ack for 3 cycles
    instr_ready = 1'b1; ack_en = 1'b0;
    step();
    for (int unsigned i = 0; i < 3; i++) begin
      check("wait_req",   32'(mem_req),     32'd1);
      check("wait_addr",  32'(mem_addr),    32'h003);
      check("wait_pc",    32'(pc),          32'h003);
      check("wait_valid", 32'(instr_valid), 32'd0);
      step();
    end
    check("wait_still_req", 32'(mem_req), 32'd1);
    ack_en = 1'b1;
    step();
    check_hold("i2", 8'h07, 8'h00, 12'h004);

    // jump together with ready in HOLD: consumed, then redirected to 0xFFF
    jump_en = 1'b1; jump_target = 12'hFFF;
    mem[12'h000] = 8'h55;
    step();
    jump_en = 1'b0;
    check("jmp_valid", 32'(instr_valid), 32'd0);
    check("jmp_pc",    32'(pc),          32'hFFF);
    check("jmp_addr",  32'(mem_addr),    32'hFFF);
    step();
    check("wrap_addr", 32'(mem_addr), 32'h000);
    step();
    check_hold("wrap", 8'h80, 8'h55, 12'h001);

    // jump collides with the literal ack: literal dropped
    step();
    step();
    check("pre_jmp_addr", 32'(mem_addr), 32'h002);
    jump_en = 1'b1; jump_target = 12'h2A0;
    step();
    jump_en = 1'b0;
    check("jlit_valid", 32'(instr_valid), 32'd0);
    check("jlit_addr",  32'(mem_addr),    32'h2A0);
    check("jlit_lit",   32'(instr_lit),   32'h55);
    check("jlit_op",    32'(instr_op),    32'h85);
    step();
    check_hold("tgt", 8'h21, 8'h00, 12'h2A1);

    // reset beats jump in FETCH_LIT
    step();
    step();
    check("pre_rst_addr", 32'(mem_addr), 32'h2A2);
    reset = 1'b1; jump_en = 1'b1; jump_target = 12'h123;
    step();
    check("rj_pc",    32'(pc),          32'h000);
    check("rj_req",   32'(mem_req),     32'd0);
    check("rj_valid", 32'(instr_valid), 32'd0);
    check("rj_op",    32'(instr_op),    32'h00);
    reset = 1'b0; jump_en = 1'b0;
    #1;
    check("rj_fetch_req",  32'(mem_req),  32'd1);
    check("rj_fetch_addr", 32'(mem_addr), 32'h000);
    step();
    check_hold("post_rst", 8'h55, 8'h00, 12'h001);

    // jump in HOLD without ready flushes the held instruction
    instr_ready = 1'b0; jump_en = 1'b1; jump_target = 12'h010;
    step();
    jump_en = 1'b0;
    check("flush_valid", 32'(instr_valid), 32'd0);
    check("flush_pc",    32'(pc),          32'h010);
    check("flush_req",   32'(mem_req),     32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
